// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and helpers for the initiator port and its watchdog.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } ahbl_resp_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } port_state_e;

  // A command is rejected locally when its size is wider than a word or its
  // address is not naturally aligned to that size.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size > HSIZE_WORD) begin
      bad = 1'b1;
    end else if (size == HSIZE_WORD) begin
      bad = (addr_lo != 2'b00);
    end else if (size == HSIZE_HALF) begin
      bad = addr_lo[0];
    end
    return bad;
  endfunction

endpackage

// File: rtl/ahbl_master_timeout.sv
// Hung-slave watchdog: counts enabled cycles and fires on the LIMIT-th one.
// LIMIT of 0 disables it entirely.
module ahbl_master_timeout #(
  parameter int unsigned LIMIT = 256
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic en,
  input  logic clr,
  output logic fire
);

  localparam int unsigned CW   = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam int unsigned LAST = (LIMIT == 0) ? 0 : LIMIT - 1;
  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  logic [CW-1:0] count;

  assign fire = (LIMIT != 0) && en && (count == LAST_C);

  // Count stalled cycles; any ready cycle or a firing restarts from zero.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      count <= '0;
    end else if (clr || fire) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ahbl_master_port.sv
// AHB-Lite initiator: turns a valid/ready command stream into SINGLE transfers
// with the address phase of the next command overlapping the current data phase.
module ahbl_master_port
  import ahbl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  port_state_e state_q, state_d;

  logic        ap_v;
  logic        ap_local;
  logic [31:0] ap_addr;
  logic        ap_write;
  logic [2:0]  ap_size;
  logic [31:0] ap_wdata;

  logic        dp_v;
  logic        dp_local;
  logic        dp_write;
  logic [31:0] dp_wdata;

  logic accept;
  logic wd_en;
  logic wd_fire;
  logic slave_err;

  assign accept    = cmd_valid & cmd_ready;
  assign slave_err = (ahbl_resp_e'(HRESP) == RESP_ERROR);
  assign wd_en     = (state_q == ST_RUN) & dp_v & ~HREADY;

  assign HADDR     = ap_addr;
  assign HWRITE    = ap_write;
  assign HSIZE     = ap_size;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA_PRIV;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = (dp_v & dp_write & ~dp_local) ? dp_wdata : 32'h0;

  ahbl_master_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .en    (wd_en),
    .clr   (HREADY),
    .fire  (wd_fire)
  );

  // Run/fault state register; only reset leaves the fault state.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, command handshake and transfer type from the current slots.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    HTRANS    = HTRANS_IDLE;
    if (state_q == ST_RUN) begin
      cmd_ready = ~ap_v | HREADY;
      if (ap_v && !ap_local) begin
        HTRANS = HTRANS_NONSEQ;
      end
      if (wd_fire) begin
        state_d = ST_FAULT;
      end
    end
  end

  // Slot pipeline and response generation: AP and DP only move on a ready
  // edge, so bus outputs stay frozen through wait states.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ap_v        <= 1'b0;
      ap_local    <= 1'b0;
      ap_addr     <= 32'h0;
      ap_write    <= 1'b0;
      ap_size     <= HSIZE_WORD;
      ap_wdata    <= 32'h0;
      dp_v        <= 1'b0;
      dp_local    <= 1'b0;
      dp_write    <= 1'b0;
      dp_wdata    <= 32'h0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= 32'h0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= 32'h0;
      if (state_q == ST_RUN) begin
        if (wd_fire) begin
          rsp_valid   <= 1'b1;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b1;
          ap_v        <= 1'b0;
          dp_v        <= 1'b0;
        end else begin
          if (HREADY) begin
            dp_v     <= ap_v;
            dp_local <= ap_local;
            dp_write <= ap_write;
            dp_wdata <= ap_wdata;
            if (dp_v) begin
              rsp_valid <= 1'b1;
              rsp_err   <= slave_err | dp_local;
              rsp_rdata <= (!dp_write && !dp_local && !slave_err) ? HRDATA : 32'h0;
            end
          end
          if (accept) begin
            ap_v     <= 1'b1;
            ap_local <= is_misaligned(cmd_size, cmd_addr[1:0]);
            ap_addr  <= cmd_addr;
            ap_write <= cmd_write;
            ap_size  <= cmd_size;
            ap_wdata <= cmd_wdata;
          end else if (HREADY) begin
            ap_v <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ahbl_master_port.sv
// Directed bench for ahbl_master_port with hand-computed expectations.
module tb_ahbl_master_port;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int total = 0;
  int bad   = 0;

  ahbl_master_port #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_write  (cmd_write),
    .cmd_size   (cmd_size),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HPROT      (HPROT),
    .HMASTLOCK  (HMASTLOCK),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP)
  );

  // Free-running bus clock.
  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                               input logic [2:0] s, input logic [31:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
  endtask

  task automatic driveSlave(input logic rdy, input logic resp, input logic [31:0] rdata);
    HREADY = rdy;
    HRESP  = resp;
    HRDATA = rdata;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic checkRsp(input string tag, input logic v, input logic e, input logic t,
                          input logic [31:0] d);
    checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'(v));
    checkOutput({tag, "_err"}, 32'(rsp_err), 32'(e));
    checkOutput({tag, "_tmo"}, 32'(rsp_timeout), 32'(t));
    checkOutput({tag, "_rdata"}, rsp_rdata, d);
  endtask

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  // Directed scenario sequence.
  initial begin
    HRESET = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b010, 32'h0);
    driveSlave(1'b1, 1'b0, 32'h0);
    step();
    step();
    checkOutput("rst_htrans", 32'(HTRANS), 32'h0);
    checkOutput("rst_haddr", HADDR, 32'h0);
    checkOutput("rst_hwrite", 32'(HWRITE), 32'h0);
    checkOutput("rst_hsize", 32'(HSIZE), 32'h2);
    checkOutput("rst_hwdata", HWDATA, 32'h0);
    checkOutput("rst_hburst", 32'(HBURST), 32'h0);
    checkOutput("rst_hprot", 32'(HPROT), 32'h3);
    checkOutput("rst_lock", 32'(HMASTLOCK), 32'h0);
    checkRsp("rst_rsp", 1'b0, 1'b0, 1'b0, 32'h0);
    HRESET = 1'b0;
    step();

    $display("[TB] write with zero wait states");
    applyStimulus(1'b1, 1'b1, 32'h4000_0010, 3'b010, 32'hDEAD_BEEF);
    #1 checkOutput("t1_ready", 32'(cmd_ready), 32'h1);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b010, 32'h0);
    checkOutput("t1_htrans", 32'(HTRANS), 32'h2);
    checkOutput("t1_hwrite", 32'(HWRITE), 32'h1);
    checkOutput("t1_haddr", HADDR, 32'h4000_0010);
    step();
    checkOutput("t1_hwdata", HWDATA, 32'hDEAD_BEEF);
    checkOutput("t1_idle", 32'(HTRANS), 32'h0);
    step();
    checkRsp("t1_rsp", 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput("t1_pulse", 32'(rsp_valid), 32'h0);

    $display("[TB] read with two wait states then write");
    applyStimulus(1'b1, 1'b0, 32'h10, 3'b010, 32'h0);
    step();
    checkOutput("t2_haddr_rd", HADDR, 32'h10);
    checkOutput("t2_htrans_rd", 32'(HTRANS), 32'h2);
    applyStimulus(1'b1, 1'b1, 32'h14, 3'b010, 32'hCAFE_F00D);
    #1 checkOutput("t2_ready_ap", 32'(cmd_ready), 32'h1);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b010, 32'h0);
    driveSlave(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("t2_haddr_w1", HADDR, 32'h14);
    checkOutput("t2_ready_wait", 32'(cmd_ready), 32'h0);
    checkOutput("t2_hwdata_rd", HWDATA, 32'h0);
    step();
    checkOutput("t2_haddr_w2", HADDR, 32'h14);
    checkOutput("t2_hwrite_w2", 32'(HWRITE), 32'h1);
    step();
    checkOutput("t2_haddr_w3", HADDR, 32'h14);
    checkOutput("t2_htrans_w3", 32'(HTRANS), 32'h2);
    driveSlave(1'b1, 1'b0, 32'h1234_5678);
    step();
    checkRsp("t2_rsp_rd", 1'b1, 1'b0, 1'b0, 32'h1234_5678);
    checkOutput("t2_hwdata_wr", HWDATA, 32'hCAFE_F00D);
    driveSlave(1'b1, 1'b0, 32'hFFFF_FFFF);
    step();
    checkRsp("t2_rsp_wr", 1'b1, 1'b0, 1'b0, 32'h0);
    driveSlave(1'b1, 1'b0, 32'h0);
    step();
    checkOutput("t2_pulse", 32'(rsp_valid), 32'h0);

    $display("[TB] two-cycle error response with read pending");
    applyStimulus(1'b1, 1'b1, 32'h20, 3'b010, 32'h0000_0055);
    step();
    applyStimulus(1'b1, 1'b0, 32'h24, 3'b010, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b010, 32'h0);
    driveSlave(1'b0, 1'b1, 32'h0);
    checkOutput("t3_hwdata", HWDATA, 32'h0000_0055);
    checkOutput("t3_haddr_1", HADDR, 32'h24);
    checkOutput("t3_htrans_1", 32'(HTRANS), 32'h2);
    step();
    driveSlave(1'b1, 1'b1, 32'h0);
    checkOutput("t3_haddr_2", HADDR, 32'h24);
    checkOutput("t3_htrans_2", 32'(HTRANS), 32'h2);
    step();
    checkRsp("t3_rsp_wr", 1'b1, 1'b1, 1'b0, 32'h0);
    driveSlave(1'b1, 1'b0, 32'hA5A5_0024);
    step();
    checkRsp("t3_rsp_rd", 1'b1, 1'b0, 1'b0, 32'hA5A5_0024);
    driveSlave(1'b1, 1'b0, 32'h0);
    step();

    $display("[TB] misaligned read followed by legal read");
    applyStimulus(1'b1, 1'b0, 32'h4000_0002, 3'b010, 32'h0);
    step();
    checkOutput("t5_idle", 32'(HTRANS), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h4000_0004, 3'b010, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b010, 32'h0);
    driveSlave(1'b1, 1'b0, 32'hFFFF_FFFF);
    checkOutput("t5_htrans_ok", 32'(HTRANS), 32'h2);
    checkOutput("t5_haddr_ok", HADDR, 32'h4000_0004);
    step();
    checkRsp("t5_rsp_bad", 1'b1, 1'b1, 1'b0, 32'h0);
    driveSlave(1'b1, 1'b0, 32'h89AB_CDEF);
    step();
    checkRsp("t5_rsp_ok", 1'b1, 1'b0, 1'b0, 32'h89AB_CDEF);
    driveSlave(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0031, 3'b001, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b010, 32'h0);
    checkOutput("t5_half_idle", 32'(HTRANS), 32'h0);
    step();
    step();
    checkRsp("t5_rsp_half", 1'b1, 1'b1, 1'b0, 32'h0);
    step();

    $display("[TB] reset during write data phase");
    applyStimulus(1'b1, 1'b1, 32'h30, 3'b010, 32'h0000_0077);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b010, 32'h0);
    step();
    checkOutput("t6_hwdata_pre", HWDATA, 32'h0000_0077);
    driveSlave(1'b0, 1'b0, 32'h0);
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    driveSlave(1'b1, 1'b0, 32'h0);
    checkOutput("t6_htrans", 32'(HTRANS), 32'h0);
    checkOutput("t6_hwdata", HWDATA, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t6_no_rsp", 32'(rsp_valid), 32'h0);
      step();
    end

    $display("[TB] watchdog with slave stuck in wait");
    applyStimulus(1'b1, 1'b0, 32'h50, 3'b010, 32'h0);
    step();
    applyStimulus(1'b1, 1'b1, 32'h54, 3'b010, 32'h0000_0099);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b010, 32'h0);
    driveSlave(1'b0, 1'b0, 32'h0);
    checkOutput("t4_htrans_ap", 32'(HTRANS), 32'h2);
    checkOutput("t4_haddr_ap", HADDR, 32'h54);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t4_no_rsp", 32'(rsp_valid), 32'h0);
      step();
    end
    checkRsp("t4_rsp_tmo", 1'b1, 1'b1, 1'b1, 32'h0);
    checkOutput("t4_htrans_flt", 32'(HTRANS), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h58, 3'b010, 32'h0);
    driveSlave(1'b1, 1'b0, 32'h0);
    #1 checkOutput("t4_ready_flt", 32'(cmd_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("t4_flt_ready", 32'(cmd_ready), 32'h0);
      checkOutput("t4_flt_htrans", 32'(HTRANS), 32'h0);
      checkOutput("t4_flt_rsp", 32'(rsp_valid), 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b010, 32'h0);
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    step();
    checkOutput("t4_ready_rst", 32'(cmd_ready), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
